// File: rtl/trace_trigger_ctrl.sv
// Trace trigger controller: watches a NoC flit stream for a masked pattern,
// fires after a programmable number of hits, then streams the firing flit and
// a programmable number of following flits to a trace buffer.
module trace_trigger_ctrl #(
    parameter int Fpay  = 32,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Fpay-1:0]  flit_in,
    input  logic             flit_valid,
    input  logic             arm,
    input  logic             disarm,
    input  logic [Fpay-1:0]  match_mask,
    input  logic [Fpay-1:0]  match_value,
    input  logic [7:0]       match_count,
    input  logic [CNT_W-1:0] post_len,
    output logic [Fpay-1:0]  trace,
    output logic             trigger,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] captured,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CAP_MAX = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [7:0]        hits_q, hits_d;
    logic [CNT_W-1:0]  captured_q, captured_d;
    logic [Fpay-1:0]   trace_q, trace_d;
    logic              trigger_q, trigger_d;

    logic              is_match;
    logic [7:0]        hit_target;
    logic [7:0]        hits_inc;
    logic [CNT_W-1:0]  cap_inc;
    logic [CNT_W:0]    cap_goal;
    logic              last_capture;
    logic              do_capture;

    // Compare terms and capture-count arithmetic shared by the next-state logic.
    // cap_goal is one bit wider so post_len = CAP_MAX does not wrap.
    always_comb begin
        is_match     = flit_valid && ((flit_in & match_mask) == (match_value & match_mask));
        hit_target   = (match_count == 8'd0) ? 8'd1 : match_count;
        hits_inc     = hits_q + 8'd1;
        cap_inc      = (captured_q == CAP_MAX) ? captured_q : captured_q + {{(CNT_W-1){1'b0}}, 1'b1};
        cap_goal     = {1'b0, post_len} + {{CNT_W{1'b0}}, 1'b1};
        last_capture = ({1'b0, cap_inc} >= cap_goal) || (cap_inc == CAP_MAX);
    end

    // Next-state logic: disarm overrides everything, arm only acts when
    // idle or done, and any capture decides between CAPTURE and DONE.
    always_comb begin
        state_d    = state_q;
        hits_d     = hits_q;
        captured_d = captured_q;
        trace_d    = trace_q;
        trigger_d  = 1'b0;
        do_capture = 1'b0;

        if (disarm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d    = ST_ARMED;
                        hits_d     = 8'd0;
                        captured_d = '0;
                    end
                end
                ST_ARMED: begin
                    if (is_match) begin
                        hits_d = hits_inc;
                        // >= rather than == so a target lowered while armed still fires
                        if (hits_inc >= hit_target) begin
                            do_capture = 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (flit_valid) begin
                        do_capture = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (do_capture) begin
            trigger_d  = 1'b1;
            trace_d    = flit_in;
            captured_d = cap_inc;
            state_d    = last_capture ? ST_DONE : ST_CAPTURE;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hits_q     <= 8'd0;
            captured_q <= '0;
            trace_q    <= '0;
            trigger_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hits_q     <= hits_d;
            captured_q <= captured_d;
            trace_q    <= trace_d;
            trigger_q  <= trigger_d;
        end
    end

    assign state    = state_q;
    assign done     = (state_q == ST_DONE);
    assign trace    = trace_q;
    assign trigger  = trigger_q;
    assign captured = captured_q;

endmodule

// File: tb/tb_trace_trigger_ctrl.sv
// Bench for trace_trigger_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model. A second instance with a
// 4-bit sample counter covers capture-count saturation.
module tb_trace_trigger_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] flit_in;
    logic        flit_valid;
    logic        arm, disarm, arm4, disarm4;
    logic [31:0] match_mask, match_value;
    logic [7:0]  match_count;
    logic [9:0]  post_len;
    logic [3:0]  post_len4;

    logic [31:0] trace, trace4;
    logic        trigger, trigger4;
    logic [1:0]  state, state4;
    logic [9:0]  captured;
    logic [3:0]  captured4;
    logic        done, done4;

    int n_assert = 0;
    int n_fail   = 0;

    trace_trigger_ctrl #(.Fpay(32), .CNT_W(10)) dut (
        .clk(clk), .reset(reset), .flit_in(flit_in), .flit_valid(flit_valid),
        .arm(arm), .disarm(disarm), .match_mask(match_mask), .match_value(match_value),
        .match_count(match_count), .post_len(post_len),
        .trace(trace), .trigger(trigger), .state(state), .captured(captured), .done(done)
    );

    trace_trigger_ctrl #(.Fpay(32), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flit_in(flit_in), .flit_valid(flit_valid),
        .arm(arm4), .disarm(disarm4), .match_mask(match_mask), .match_value(match_value),
        .match_count(match_count), .post_len(post_len4),
        .trace(trace4), .trigger(trigger4), .state(state4), .captured(captured4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 watching, 2 recording, 3 finished.
    typedef struct packed {
        int          st;
        int          hits;
        int          cap;
        logic        trig;
        logic [31:0] tr;
    } model_t;

    localparam model_t MODEL_RST = '{st: 0, hits: 0, cap: 0, trig: 1'b0, tr: 32'h0};

    model_t m, m4;
    int     trig_cnt, trig_cnt4;
    logic [31:0] trace_log[$];
    logic [31:0] exp_log[$];

    function automatic model_t model_next(model_t cur, bit a, bit d, bit v, logic [31:0] f,
                                          logic [31:0] mk, logic [31:0] vl, int mc, int pl,
                                          int capmax);
        model_t n;
        bit     grab;
        n      = cur;
        grab   = 1'b0;
        n.trig = 1'b0;
        if (d) begin
            n.st = 0;
            return n;
        end
        if (cur.st == 0 || cur.st == 3) begin
            if (a) begin
                n.st   = 1;
                n.hits = 0;
                n.cap  = 0;
            end
        end else if (cur.st == 1) begin
            if (v && (((f ^ vl) & mk) == 32'h0)) begin
                n.hits = cur.hits + 1;
                if (n.hits == ((mc == 0) ? 1 : mc)) grab = 1'b1;
            end
        end else begin
            if (v) grab = 1'b1;
        end
        if (grab) begin
            n.trig = 1'b1;
            n.tr   = f;
            n.cap  = (cur.cap + 1 > capmax) ? capmax : cur.cap + 1;
            n.st   = (n.cap >= pl + 1 || n.cap == capmax) ? 3 : 2;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("state",     64'(state),     64'(m.st));
        chk("trigger",   64'(trigger),   64'(m.trig));
        chk("trace",     64'(trace),     64'(m.tr));
        chk("captured",  64'(captured),  64'(m.cap));
        chk("done",      64'(done),      64'(m.st == 3));
        chk("state4",    64'(state4),    64'(m4.st));
        chk("trigger4",  64'(trigger4),  64'(m4.trig));
        chk("trace4",    64'(trace4),    64'(m4.tr));
        chk("captured4", 64'(captured4), 64'(m4.cap));
        chk("done4",     64'(done4),     64'(m4.st == 3));
    endtask

    // One clock: advance the model on the same edge, check 1 time unit later,
    // then drop the single-cycle request pulses.
    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            m  = MODEL_RST;
            m4 = MODEL_RST;
        end else begin
            m  = model_next(m, arm, disarm, flit_valid, flit_in, match_mask, match_value,
                            int'(match_count), int'(post_len), 1023);
            m4 = model_next(m4, arm4, disarm4, flit_valid, flit_in, match_mask, match_value,
                            int'(match_count), int'(post_len4), 15);
        end
        #1;
        check_all();
        if (trigger === 1'b1) begin
            trig_cnt++;
            trace_log.push_back(trace);
        end
        if (trigger4 === 1'b1) trig_cnt4++;
        $display("t=%0t arm=%0b dis=%0b v=%0b flit=%h | st=%0d trig=%0b trace=%h cap=%0d | st4=%0d trig4=%0b cap4=%0d",
                 $time, arm, disarm, flit_valid, flit_in, state, trigger, trace, captured,
                 state4, trigger4, captured4);
        arm     = 1'b0;
        disarm  = 1'b0;
        arm4    = 1'b0;
        disarm4 = 1'b0;
    endtask

    task automatic fl(input bit v, input logic [31:0] data);
        flit_valid = v;
        flit_in    = data;
        cycle();
    endtask

    task automatic clear_tally();
        trig_cnt  = 0;
        trig_cnt4 = 0;
        trace_log.delete();
        exp_log.delete();
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, 64'(trace_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size(); i++) begin
            chk(tag, (i < trace_log.size()) ? 64'(trace_log[i]) : 64'hx, 64'(exp_log[i]));
        end
    endtask

    initial begin
        reset = 1'b1; flit_in = '0; flit_valid = 1'b0;
        arm = 1'b0; disarm = 1'b0; arm4 = 1'b0; disarm4 = 1'b0;
        match_mask = '0; match_value = '0; match_count = 8'd1;
        post_len = '0; post_len4 = '0;
        m = MODEL_RST; m4 = MODEL_RST;
        clear_tally();

        // Reset state before any clock edge
        #3;
        check_all();
        cycle();
        reset = 1'b0;
        fl(1'b1, 32'h1234);
        fl(1'b0, 32'h0);

        // Exact match, single hit, three post-trigger flits
        match_mask = 32'hFFFF_FFFF; match_value = 32'hDEAD_BEEF;
        match_count = 8'd1; post_len = 10'd3;
        arm = 1'b1; fl(1'b0, 32'h0);
        clear_tally();
        fl(1'b1, 32'h0000_AAAA);
        fl(1'b1, 32'hDEAD_BEEF);
        fl(1'b1, 32'h1);
        fl(1'b1, 32'h2);
        fl(1'b1, 32'h3);
        fl(1'b1, 32'h4);
        fl(1'b0, 32'h0);
        fl(1'b0, 32'h0);
        exp_log = '{32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3};
        check_log("s1_trace");
        chk("s1_captured", 64'(captured), 64'd4);
        chk("s1_done",     64'(done),     64'd1);

        // Third masked hit fires, no post-trigger flits (re-armed from DONE)
        match_mask = 32'h0000_00FF; match_value = 32'h0000_0011;
        match_count = 8'd3; post_len = 10'd0;
        arm = 1'b1; fl(1'b0, 32'h0);
        clear_tally();
        fl(1'b1, 32'h0000_0100);
        fl(1'b1, 32'h0000_0211);
        fl(1'b1, 32'h0000_0322);
        fl(1'b1, 32'h0000_0411);
        fl(1'b1, 32'h0000_0511);
        fl(1'b1, 32'h0000_0600);
        fl(1'b0, 32'h0);
        exp_log = '{32'h0000_0511};
        check_log("s2_trace");
        chk("s2_captured", 64'(captured), 64'd1);
        chk("s2_state",    64'(state),    64'd3);

        // Disarm in the middle of a capture
        match_mask = 32'h0; match_value = 32'h0; match_count = 8'd1; post_len = 10'd10;
        arm = 1'b1; fl(1'b0, 32'h0);
        clear_tally();
        fl(1'b1, 32'h10);
        fl(1'b1, 32'h11);
        fl(1'b1, 32'h12);
        disarm = 1'b1; fl(1'b1, 32'h13);
        chk("s3_state_after_disarm", 64'(state), 64'd0);
        chk("s3_no_trig_in_disarm",  64'(trigger), 64'd0);
        fl(1'b1, 32'h14);
        exp_log = '{32'h10, 32'h11, 32'h12};
        check_log("s3_trace");
        chk("s3_captured", 64'(captured), 64'd3);

        // 4-bit counter instance: capture saturates at 15 samples
        post_len4 = 4'd15;
        arm4 = 1'b1; fl(1'b1, 32'h0FF);
        clear_tally();
        for (int i = 0; i < 20; i++) fl(1'b1, 32'h100 + 32'(i));
        chk("s4_trig_cnt",  64'(trig_cnt4), 64'd15);
        chk("s4_captured",  64'(captured4), 64'd15);
        chk("s4_state",     64'(state4),    64'd3);

        // Gaps in flit_valid while capturing
        post_len = 10'd2;
        arm = 1'b1; fl(1'b0, 32'h0);
        clear_tally();
        fl(1'b1, 32'h20);
        fl(1'b0, 32'hBAD0);
        fl(1'b1, 32'h21);
        fl(1'b0, 32'hBAD1);
        fl(1'b1, 32'h22);
        fl(1'b0, 32'hBAD2);
        fl(1'b1, 32'h23);
        exp_log = '{32'h20, 32'h21, 32'h22};
        check_log("s5_trace");
        chk("s5_state", 64'(state), 64'd3);

        // arm+disarm together, then asynchronous reset during capture
        disarm = 1'b1; fl(1'b0, 32'h0);
        arm = 1'b1; disarm = 1'b1; fl(1'b1, 32'h0);
        chk("s6_arm_disarm_idle", 64'(state), 64'd0);
        post_len = 10'd10;
        arm = 1'b1; fl(1'b0, 32'h0);
        fl(1'b1, 32'h30);
        fl(1'b1, 32'h31);
        chk("s6_in_capture", 64'(state), 64'd2);
        #2 reset = 1'b1;
        #1;
        m = MODEL_RST; m4 = MODEL_RST;
        check_all();
        chk("s6_async_trigger", 64'(trigger), 64'd0);
        chk("s6_async_state",   64'(state),   64'd0);
        clear_tally();
        fl(1'b1, 32'h32);
        fl(1'b1, 32'h33);
        reset = 1'b0;
        fl(1'b1, 32'h34);
        fl(1'b1, 32'h35);
        fl(1'b1, 32'h36);
        chk("s6_no_trig_after_reset", 64'(trig_cnt), 64'd0);
        chk("s6_stays_idle", 64'(state), 64'd0);

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            if ((m.st == 0 || m.st == 3) && (m4.st == 0 || m4.st == 3) &&
                $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: match_mask = 32'h0;
                    1: match_mask = 32'h3;
                    default: match_mask = 32'hF;
                endcase
                match_value = $urandom;
                match_count = 8'($urandom_range(0, 3));
                post_len    = 10'($urandom_range(0, 6));
            end
            if ((m4.st == 0 || m4.st == 3) && $urandom_range(0, 3) == 0)
                post_len4 = 4'($urandom_range(0, 15));
            arm     = ($urandom_range(0, 7) == 0);
            disarm  = ($urandom_range(0, 39) == 0);
            arm4    = ($urandom_range(0, 7) == 0);
            disarm4 = ($urandom_range(0, 39) == 0);
            fl($urandom_range(0, 3) != 0, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_trigger_ctrl.md
TRACE_TRIGGER_CTRL -- requirements
Module: trace_trigger_ctrl

Interface
REQ-001 The block SHALL have parameter Fpay, default 32, meaning the captured flit payload width.
REQ-002 The block SHALL have parameter CNT_W, default 10, meaning the sample-counter width; the maximum capture is CAP_MAX = 2^CNT_W - 1 samples.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port flit_in, input, Fpay bits: the monitored NoC flit payload.
REQ-006 The block SHALL have port flit_valid, input, 1 bit: flit_in is valid this cycle.
REQ-007 The block SHALL have port arm, input, 1 bit: single-cycle request to start watching for the trigger condition.
REQ-008 The block SHALL have port disarm, input, 1 bit: single-cycle abort request.
REQ-009 The block SHALL have port match_mask, input, Fpay bits: bit-enable mask for the compare; quasi-static while armed.
REQ-010 The block SHALL have port match_value, input, Fpay bits: compare pattern; quasi-static while armed.
REQ-011 The block SHALL have port match_count, input, 8 bits: number of matching flits required to fire; 0 is treated as 1.
REQ-012 The block SHALL have port post_len, input, CNT_W bits: number of flits captured after the firing flit.
REQ-013 The block SHALL have port trace, output, Fpay bits: data to the trace buffer.
REQ-014 The block SHALL have port trigger, output, 1 bit: trace buffer write enable, one write per high cycle.
REQ-015 The block SHALL have port state, output, 2 bits: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-016 The block SHALL have port captured, output, CNT_W bits: number of samples written since the last arm.
REQ-017 The block SHALL have port done, output, 1 bit: high while state is DONE.

Function
REQ-018 A flit SHALL be a "match" when flit_valid=1 and (flit_in & match_mask) == (match_value & match_mask); all-zero mask matches every valid flit.
REQ-019 In IDLE, arm=1 SHALL clear the hit counter and captured, and move to ARMED next cycle; flits are ignored in IDLE.
REQ-020 In ARMED, each match SHALL increment an 8-bit hit counter; the match that makes hits equal max(match_count,1) SHALL fire, capturing that flit and moving to CAPTURE.
REQ-021 In CAPTURE, every valid flit SHALL be captured regardless of match.
REQ-022 Capture SHALL be registered: a flit captured in cycle N SHALL give trace=flit_in and trigger=1 in cycle N+1; otherwise trigger=0 and trace holds its last value.
REQ-023 captured SHALL increment by one per captured flit, saturating at CAP_MAX.
REQ-024 When the total captured (firing flit + post-trigger flits) reaches post_len+1, or reaches CAP_MAX, the block SHALL move to DONE on the edge of the last capture; post_len=0 therefore goes ARMED->DONE directly, capturing only the firing flit.
REQ-025 In DONE, done=1; no further captures occur; arm=1 SHALL re-arm exactly as from IDLE (counters cleared, go to ARMED).
REQ-026 arm asserted in ARMED or CAPTURE SHALL be ignored.
REQ-027 disarm=1 in any state SHALL move to IDLE next cycle and suppress any capture in that cycle; captured keeps its value.
REQ-028 If arm and disarm are asserted together, disarm SHALL win.
REQ-029 Hit-counter overflow SHALL NOT occur, since firing happens at most at 255 hits.

Reset
REQ-030 While reset=1, the block SHALL hold state=IDLE, trace=0, trigger=0, captured=0, done=0, and hit counter=0, regardless of clk.
REQ-031 Reset asserted mid-capture SHALL abort immediately with no further trigger pulses; after release the block SHALL stay in IDLE until arm.

Verification
REQ-032 Bench scenario: mask=FFFF_FFFF, value=DEAD_BEEF, match_count=1, post_len=3; arm, then flits AAAA, DEAD_BEEF, 1, 2, 3, 4 on consecutive cycles -> trigger high for exactly 4 cycles with trace DEAD_BEEF, 1, 2, 3; captured=4; done=1; flit 4 not captured.
REQ-033 Bench scenario: match_count=3, mask=0000_00FF, value=0000_0011, post_len=0; six valid flits of which the 2nd, 4th and 5th end in 0x11 -> single trigger pulse carrying the 5th flit; captured=1; state=DONE.
REQ-034 Bench scenario: in CAPTURE with post_len=10, disarm after 2 post-trigger captures -> state IDLE next cycle, no trigger in the disarm cycle or after it, captured=3.
REQ-035 Bench scenario: CNT_W=4, post_len=15, continuous valid flits after firing -> exactly 15 trigger pulses, captured=15, state DONE.
REQ-036 Bench scenario: arm and disarm pulsed in the same cycle from IDLE -> remains IDLE; then assert reset during CAPTURE -> all outputs 0 asynchronously, state IDLE.
REQ-037 Bench scenario: flit_valid gaps during CAPTURE (valid on alternate cycles, post_len=2) -> trigger pulses only one cycle after each valid flit, then DONE.
